multi_alarm_controller: RTL and testbench

Parametrised alarm controller for the alarm clock, holding NUM_ALARMS independent daily alarms, each with its own time and enable. The user selects and sets alarms using debounced button levels; button edges are detected internally. The controller compares the enabled alarms against the real-time clock once per minute and drives a ringing indication, with snooze, dismiss and ring timeout. The ringing output feeds the sound interface; the selected-alarm outputs feed the display mux.

---
 rtl/multi_alarm_controller.sv | 225 ++++++++++++++++++++++
 tb/tb_multi_alarm_controller.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_alarm_controller.sv
// Multi-channel daily alarm controller: set, select, match, ring,
// snooze, dismiss and unanswered-ring timeout.
module multi_alarm_controller #(
  parameter int NUM_ALARMS        = 4,
  parameter int SNOOZE_MINS       = 9,
  parameter int RING_TIMEOUT_MINS = 5,
  localparam int IW = $clog2(NUM_ALARMS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  btn_set,
  input  logic                  btn_inc_hours,
  input  logic                  btn_inc_mins,
  input  logic                  btn_select,
  input  logic                  btn_snooze,
  input  logic                  btn_dismiss,
  input  logic [7:0]            real_hours,
  input  logic [7:0]            real_mins,
  input  logic                  min_tick,
  output logic [IW-1:0]         sel_index,
  output logic [7:0]            sel_hours,
  output logic [7:0]            sel_mins,
  output logic [NUM_ALARMS-1:0] alarm_enabled,
  output logic                  setting,
  output logic                  ringing,
  output logic [IW-1:0]         ring_index,
  output logic                  snoozed
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SET_H,
    S_SET_M,
    S_RING,
    S_SNZ
  } state_e;

  state_e state_q, state_d;

  logic [5:0] btn, btn_q, pr;

  logic [NUM_ALARMS-1:0][7:0] hours_q, hours_d;
  logic [NUM_ALARMS-1:0][7:0] mins_q, mins_d;
  logic [NUM_ALARMS-1:0]      en_q, en_d;
  logic [IW-1:0]              sel_q, sel_d;
  logic [IW-1:0]              ring_idx_q, ring_idx_d;
  logic [7:0]                 snz_h_q, snz_h_d;
  logic [7:0]                 snz_m_q, snz_m_d;
  logic [3:0]                 tmo_q, tmo_d;

  logic          real_ok;
  logic          any_match;
  logic          hit;
  logic [IW-1:0] hit_idx;
  logic          snz_hit;
  logic [3:0]    tmo_next;
  logic          tmo_done;
  logic [7:0]    m_sum, m_tgt;
  logic          m_carry;
  logic [7:0]    h_sum, h_tgt;
  logic [7:0]    cur_h, cur_m;

  wire pr_set   = pr[0];
  wire pr_inc_h = pr[1];
  wire pr_inc_m = pr[2];
  wire pr_sel   = pr[3];
  wire pr_snz   = pr[4];
  wire pr_dis   = pr[5];

  assign btn = {btn_dismiss, btn_snooze, btn_select,
                btn_inc_mins, btn_inc_hours, btn_set};
  assign pr  = btn & ~btn_q;

  assign real_ok = (real_hours < 8'd24) && (real_mins < 8'd60);
  assign cur_h   = hours_q[sel_q];
  assign cur_m   = mins_q[sel_q];

  // Scan downward so the lowest matching index is the one kept.
  always_comb begin
    any_match = 1'b0;
    hit_idx   = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (en_q[i] && hours_q[i] == real_hours
          && mins_q[i] == real_mins) begin
        any_match = 1'b1;
        hit_idx   = IW'(i);
      end
    end
  end

  assign hit = any_match && min_tick && real_ok;

  assign snz_hit = min_tick && real_ok
                   && real_hours == snz_h_q
                   && real_mins == snz_m_q;

  assign tmo_next = tmo_q + 4'd1;
  assign tmo_done = tmo_next == 4'(RING_TIMEOUT_MINS);

  assign m_sum   = real_mins + 8'(SNOOZE_MINS);
  assign m_carry = m_sum >= 8'd60;
  assign m_tgt   = m_carry ? m_sum - 8'd60 : m_sum;
  assign h_sum   = real_hours + {7'd0, m_carry};
  assign h_tgt   = (h_sum >= 8'd24) ? h_sum - 8'd24 : h_sum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (hit)          state_d = S_RING;
        else if (pr_set)  state_d = S_SET_H;
      end
      S_SET_H: begin
        if (!pr_inc_h && pr_set) state_d = S_SET_M;
      end
      S_SET_M: begin
        if (!pr_inc_m && pr_set) state_d = S_IDLE;
      end
      S_RING: begin
        if (pr_dis)                     state_d = S_IDLE;
        else if (pr_snz)                state_d = S_SNZ;
        else if (min_tick && tmo_done)  state_d = S_IDLE;
      end
      S_SNZ: begin
        if (pr_dis)        state_d = S_IDLE;
        else if (snz_hit)  state_d = S_RING;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    hours_d    = hours_q;
    mins_d     = mins_q;
    en_d       = en_q;
    sel_d      = sel_q;
    ring_idx_d = ring_idx_q;
    snz_h_d    = snz_h_q;
    snz_m_d    = snz_m_q;
    tmo_d      = tmo_q;
    unique case (state_q)
      S_IDLE: begin
        if (hit) begin
          ring_idx_d = hit_idx;
          tmo_d      = '0;
        end else if (pr_set) begin
          sel_d = sel_q;
        end else if (pr_sel) begin
          sel_d = (sel_q == IW'(NUM_ALARMS - 1))
                  ? '0 : sel_q + IW'(1);
        end else if (pr_dis) begin
          en_d[sel_q] = 1'b0;
        end
      end
      S_SET_H: begin
        if (pr_inc_h)
          hours_d[sel_q] = (cur_h >= 8'd23) ? 8'd0 : cur_h + 8'd1;
      end
      S_SET_M: begin
        if (pr_inc_m)
          mins_d[sel_q] = (cur_m >= 8'd59) ? 8'd0 : cur_m + 8'd1;
        else if (pr_set)
          en_d[sel_q] = 1'b1;
      end
      S_RING: begin
        if (pr_dis) begin
          tmo_d = tmo_q;
        end else if (pr_snz) begin
          snz_h_d = h_tgt;
          snz_m_d = m_tgt;
        end else if (min_tick) begin
          tmo_d = tmo_next;
        end
      end
      S_SNZ: begin
        if (!pr_dis && snz_hit) tmo_d = '0;
      end
      default: tmo_d = tmo_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_q      <= '0;
      hours_q    <= '0;
      mins_q     <= '0;
      en_q       <= '0;
      sel_q      <= '0;
      ring_idx_q <= '0;
      snz_h_q    <= '0;
      snz_m_q    <= '0;
      tmo_q      <= '0;
    end else begin
      btn_q      <= btn;
      hours_q    <= hours_d;
      mins_q     <= mins_d;
      en_q       <= en_d;
      sel_q      <= sel_d;
      ring_idx_q <= ring_idx_d;
      snz_h_q    <= snz_h_d;
      snz_m_q    <= snz_m_d;
      tmo_q      <= tmo_d;
    end
  end

  always_comb begin
    sel_index     = sel_q;
    sel_hours     = cur_h;
    sel_mins      = cur_m;
    alarm_enabled = en_q;
    ring_index    = ring_idx_q;
    setting       = (state_q == S_SET_H) || (state_q == S_SET_M);
    ringing       = state_q == S_RING;
    snoozed       = state_q == S_SNZ;
  end

endmodule

// File: tb/tb_multi_alarm_controller.sv
// Bench for multi_alarm_controller: directed scenarios plus random
// traffic, scored against a minute-count reference model.
module tb_multi_alarm_controller;

  localparam int N  = 4;
  localparam int SN = 9;
  localparam int TO = 5;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic reset;
  logic btn_set, btn_inc_hours, btn_inc_mins;
  logic btn_select, btn_snooze, btn_dismiss;
  logic [7:0] real_hours, real_mins;
  logic min_tick;
  logic [IW-1:0] sel_index, ring_index;
  logic [7:0] sel_hours, sel_mins;
  logic [N-1:0] alarm_enabled;
  logic setting, ringing, snoozed;

  always #5 clk = ~clk;

  multi_alarm_controller #(
    .NUM_ALARMS(N),
    .SNOOZE_MINS(SN),
    .RING_TIMEOUT_MINS(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_set(btn_set),
    .btn_inc_hours(btn_inc_hours),
    .btn_inc_mins(btn_inc_mins),
    .btn_select(btn_select),
    .btn_snooze(btn_snooze),
    .btn_dismiss(btn_dismiss),
    .real_hours(real_hours),
    .real_mins(real_mins),
    .min_tick(min_tick),
    .sel_index(sel_index),
    .sel_hours(sel_hours),
    .sel_mins(sel_mins),
    .alarm_enabled(alarm_enabled),
    .setting(setting),
    .ringing(ringing),
    .ring_index(ring_index),
    .snoozed(snoozed)
  );

  typedef struct packed {
    logic [IW-1:0] si;
    logic [7:0]    sh;
    logic [7:0]    sm;
    logic [N-1:0]  en;
    logic          st;
    logic          rg;
    logic [IW-1:0] ri;
    logic          sz;
  } obs_t;

  obs_t expq[$];
  int checks = 0;
  int failures = 0;

  typedef enum {M_IDLE, M_SH, M_SM, M_RING, M_SNZ} mst_e;
  mst_e ms;
  int msel, mri, mcnt, mtgt;
  int mh[N];
  int mm[N];
  bit men[N];
  bit [5:0] mprev;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic obs_t dut_obs();
    return {sel_index, sel_hours, sel_mins, alarm_enabled,
            setting, ringing, ring_index, snoozed};
  endfunction

  function automatic obs_t mobs();
    obs_t o;
    o.si = IW'(msel);
    o.sh = 8'(mh[msel]);
    o.sm = 8'(mm[msel]);
    for (int i = 0; i < N; i++) o.en[i] = men[i];
    o.st = (ms == M_SH) || (ms == M_SM);
    o.rg = ms == M_RING;
    o.ri = IW'(mri);
    o.sz = ms == M_SNZ;
    return o;
  endfunction

  task automatic model_reset();
    ms = M_IDLE; msel = 0; mri = 0; mcnt = 0; mtgt = 0; mprev = '0;
    for (int i = 0; i < N; i++) begin
      mh[i] = 0; mm[i] = 0; men[i] = 0;
    end
  endtask

  // bit order: 0 set, 1 inc_h, 2 inc_m, 3 select, 4 snooze, 5 dismiss
  task automatic model_step(bit [5:0] b, int rh, int rm, bit tick);
    bit [5:0] p;
    int rt, hit;
    bit valid;
    p = b & ~mprev;
    mprev = b;
    rt = rh * 60 + rm;
    valid = (rh < 24) && (rm < 60);
    case (ms)
      M_IDLE: begin
        hit = -1;
        if (tick && valid)
          for (int i = 0; i < N; i++)
            if (hit < 0 && men[i] && mh[i] * 60 + mm[i] == rt) hit = i;
        if (hit >= 0) begin ms = M_RING; mri = hit; mcnt = 0; end
        else if (p[0]) ms = M_SH;
        else if (p[3]) msel = (msel + 1) % N;
        else if (p[5]) men[msel] = 0;
      end
      M_SH: begin
        if (p[1]) mh[msel] = (mh[msel] + 1) % 24;
        else if (p[0]) ms = M_SM;
      end
      M_SM: begin
        if (p[2]) mm[msel] = (mm[msel] + 1) % 60;
        else if (p[0]) begin ms = M_IDLE; men[msel] = 1; end
      end
      M_RING: begin
        if (p[5]) ms = M_IDLE;
        else if (p[4]) begin ms = M_SNZ; mtgt = (rt + SN) % 1440; end
        else if (tick) begin
          mcnt++;
          if (mcnt == TO) ms = M_IDLE;
        end
      end
      M_SNZ: begin
        if (p[5]) ms = M_IDLE;
        else if (tick && valid && rt == mtgt) begin
          ms = M_RING; mcnt = 0;
        end
      end
      default: ms = M_IDLE;
    endcase
  endtask

  task automatic drive(bit rst, bit [5:0] b, int rh, int rm, bit tick);
    reset = rst;
    {btn_dismiss, btn_snooze, btn_select,
     btn_inc_mins, btn_inc_hours, btn_set} = b;
    real_hours = 8'(rh);
    real_mins = 8'(rm);
    min_tick = tick;
  endtask

  task automatic cyc(bit rst, bit [5:0] b, int rh, int rm, bit tick);
    @(negedge clk);
    drive(rst, b, rh, rm, tick);
    if (rst) model_reset();
    else model_step(b, rh, rm, tick);
    expq.push_back(mobs());
    @(posedge clk);
  endtask

  task automatic press(int k);
    cyc(0, 6'(1 << k), 0, 0, 0);
    cyc(0, 6'd0, 0, 0, 0);
  endtask

  task automatic set_alarm(int h, int m);
    press(0);
    repeat (h) press(1);
    press(0);
    repeat (m) press(2);
    press(0);
  endtask

  initial begin
    obs_t e;
    forever begin
      @(posedge clk);
      #2;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("outputs", 32'(dut_obs()), 32'(e));
      end
    end
  end

  initial begin
    bit [5:0] b;
    int rh, rm, k;
    bit tk;
    drive(1, 6'd0, 0, 0, 0);
    model_reset();
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    #3 chk("reset_state", 32'(dut_obs()), 32'd0);

    set_alarm(7, 30);
    #3;
    chk("set_hours", sel_hours, 7);
    chk("set_mins", sel_mins, 30);
    chk("set_enable", alarm_enabled, 4'b0001);
    cyc(0, 0, 7, 30, 1);
    #3;
    chk("match_ring", ringing, 1);
    chk("match_idx", ring_index, 0);

    cyc(0, 6'h10, 6, 55, 0);
    cyc(0, 0, 6, 55, 0);
    #3 chk("snoozed", {ringing, snoozed}, 2'b01);
    cyc(0, 0, 7, 3, 1);
    #3 chk("snz_early", snoozed, 1);
    cyc(0, 0, 7, 4, 1);
    #3 chk("snz_ring", {ringing, ring_index}, {1'b1, 2'd0});

    repeat (TO - 1) cyc(0, 0, 9, 0, 1);
    #3 chk("tmo_before", ringing, 1);
    cyc(0, 0, 9, 0, 1);
    #3 chk("tmo_after", {ringing, snoozed, alarm_enabled}, {2'b00, 4'b0001});

    press(3);
    set_alarm(12, 0);
    press(3);
    press(3);
    set_alarm(12, 0);
    #3 chk("multi_en", alarm_enabled, 4'b1011);
    cyc(0, 0, 12, 0, 1);
    #3 chk("lowest_idx", {ringing, ring_index}, {1'b1, 2'd1});
    cyc(0, 0, 12, 0, 1);
    #3 chk("no_requeue", {ringing, ring_index}, {1'b1, 2'd1});
    cyc(0, 6'h30, 12, 1, 0);
    cyc(0, 0, 12, 1, 0);
    #3 chk("dismiss_wins", {ringing, snoozed}, 2'b00);

    press(0);
    repeat (11) press(1);
    #3 chk("hours_23", sel_hours, 23);
    press(1);
    #3 chk("hours_wrap", sel_hours, 0);
    press(0);
    repeat (59) press(2);
    #3 chk("mins_59", sel_mins, 59);
    press(2);
    #3 chk("mins_wrap", sel_mins, 0);
    press(0);
    press(0);
    repeat (100) cyc(0, 6'h02, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    #3 chk("hold_once", sel_hours, 1);
    press(0);
    press(0);

    cyc(0, 0, 0, 60, 1);
    #3 chk("out_of_range", ringing, 0);
    cyc(0, 0, 1, 0, 1);
    #3 chk("ring_idx3", {ringing, ring_index}, {1'b1, 2'd3});
    cyc(0, 6'h10, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    #3 chk("snz_idx3", snoozed, 1);
    @(negedge clk);
    drive(1, 0, 0, 0, 0);
    model_reset();
    expq.push_back(mobs());
    #1 chk("async_reset", 32'(dut_obs()), 32'd0);
    @(posedge clk);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 5; i++) b[i] = ($urandom_range(0, 3) == 0);
      b[5] = ($urandom_range(0, 15) == 0);
      tk = ($urandom_range(0, 3) == 0);
      k = $urandom_range(0, N);
      if ($urandom_range(0, 1) == 1) begin
        if (k == N) begin rh = mtgt / 60; rm = mtgt % 60; end
        else begin rh = mh[k]; rm = mm[k]; end
      end else begin
        rh = $urandom_range(0, 23);
        rm = $urandom_range(0, 59);
      end
      cyc(($urandom_range(0, 499) == 0), b, rh, rm, tk);
    end

    cyc(0, 0, 0, 0, 0);
    @(posedge clk);
    #5 chk("queue_drained", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
